// File: rtl/sd_write_if.sv
// Bus bundle between the DRAM-to-SD bridge controller / SD card pins and the
// SD write engine. The master side owns the request and the card's MISO line;
// the slave side (the engine) drives MOSI and the status strobes.
interface sd_write_if;
  logic        start;
  logic [15:0] addr;
  logic [63:0] data;
  logic        miso;
  logic        mosi;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  modport master (
    output start, addr, data, miso,
    input  mosi, busy, done, err
  );

  modport slave (
    input  start, addr, data, miso,
    output mosi, busy, done, err
  );
endinterface

// File: rtl/sd_write_engine.sv
// SD single-block write front-end: serialises CMD24 with CRC7, collects R1,
// sends the data token, a 64-bit payload and its CRC16, collects the data
// response and waits for the card to release busy. Any card wait longer than
// TIMEOUT cycles aborts the transaction with err=3.
module sd_write_engine #(
  parameter int NWR     = 1,
  parameter int TIMEOUT = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  sd_write_if.slave   bus
);

  localparam int CNT_W   = 16;
  localparam int TMO_W   = $clog2(TIMEOUT + 1);
  localparam int GAP_CYC = 8 * NWR;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_RSP,
    S_RSP,
    S_GAP,
    S_DATA,
    S_WAIT_DRSP,
    S_DRSP,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [6:0]         rcv_q, rcv_d;
  logic [87:0]        sh_q, sh_d;
  logic [63:0]        data_q, data_d;
  logic               mosi_q, mosi_d;
  logic [1:0]         err_q, err_d;

  logic [47:0]        cmd_frame;
  logic [87:0]        data_frame;
  logic [7:0]         rsp_full;

  // CRC7 over the command header, polynomial x^7+x^3+1, MSB first, init 0.
  function automatic logic [6:0] crc7_calc(input logic [39:0] bits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // CRC16-CCITT over the payload, polynomial x^16+x^12+x^5+1, MSB first, init 0.
  function automatic logic [15:0] crc16_calc(input logic [63:0] bits);
    logic [15:0] c;
    logic        fb;
    c = '0;
    for (int i = 63; i >= 0; i--) begin
      fb = bits[i] ^ c[15];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // The command frame is built from the live address so bit 47 can leave on
  // the very next cycle; the data frame is built from the latched payload.
  assign cmd_frame  = {2'b01, 6'd24, 16'h0000, bus.addr,
                       crc7_calc({2'b01, 6'd24, 16'h0000, bus.addr}), 1'b1};
  assign data_frame = {8'hFE, data_q, crc16_calc(data_q)};

  // Response byte as it will stand after the current MISO sample is shifted in.
  assign rsp_full   = {rcv_q, bus.miso};

  assign bus.mosi = mosi_q;
  assign bus.busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done = (state_q == S_DONE);
  assign bus.err  = err_q;

  // Next-state, serialiser and response-capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    rcv_d   = rcv_q;
    sh_d    = sh_q;
    data_d  = data_q;
    mosi_d  = 1'b1;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          data_d  = bus.data;
          sh_d    = {cmd_frame[46:0], {41{1'b1}}};
          mosi_d  = cmd_frame[47];
          cnt_d   = '0;
          state_d = S_CMD;
        end
      end

      S_CMD: begin
        if (cnt_q == CNT_W'(47)) begin
          tmo_d   = '0;
          state_d = S_WAIT_RSP;
        end else begin
          mosi_d = sh_q[87];
          sh_d   = {sh_q[86:0], 1'b1};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_RSP: begin
        if (!bus.miso) begin
          rcv_d   = '0;
          cnt_d   = '0;
          state_d = S_RSP;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 2'd3;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_RSP: begin
        rcv_d = rsp_full[6:0];
        if (cnt_q == CNT_W'(6)) begin
          cnt_d = '0;
          if (rsp_full == 8'h00) begin
            state_d = S_GAP;
          end else begin
            err_d   = 2'd1;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          mosi_d  = data_frame[87];
          sh_d    = {data_frame[86:0], 1'b1};
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_W'(87)) begin
          tmo_d   = '0;
          state_d = S_WAIT_DRSP;
        end else begin
          mosi_d = sh_q[87];
          sh_d   = {sh_q[86:0], 1'b1};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_DRSP: begin
        if (!bus.miso) begin
          rcv_d   = '0;
          cnt_d   = '0;
          state_d = S_DRSP;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 2'd3;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_DRSP: begin
        rcv_d = rsp_full[6:0];
        if (cnt_q == CNT_W'(6)) begin
          cnt_d = '0;
          if ((rsp_full & 8'h1F) == 8'h05) begin
            tmo_d   = '0;
            state_d = S_BUSY;
          end else begin
            err_d   = 2'd2;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BUSY: begin
        if (bus.miso) begin
          err_d   = 2'd0;
          state_d = S_DONE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 2'd3;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, shift register and latches; reset aborts any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      rcv_q   <= '0;
      sh_q    <= '1;
      data_q  <= '0;
      mosi_q  <= 1'b1;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rcv_q   <= rcv_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      mosi_q  <= mosi_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sd_write_engine.sv
// Directed bench for sd_write_engine: a cycle-indexed card model answers on
// MISO while every MOSI bit is recorded and compared against hand-derived
// frames, CRC reference values and expected done cycles.
module tb_sd_write_engine;

  localparam int NWR     = 1;
  localparam int TIMEOUT = 50;
  localparam int MAXC    = 400;

  logic clk;
  logic rst_n;

  sd_write_if bus ();

  sd_write_engine #(.NWR(NWR), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  // Card behaviour for the current transaction.
  logic [7:0] c_r1;
  int         c_r1_dly;
  logic [7:0] c_drsp;
  int         c_d_dly;
  int         c_busy_n;

  // Per-transaction capture, indexed by cycles after the start edge.
  logic       mo [0:511];
  int         done_cyc;
  int         done_cnt;
  logic [1:0] err_at_done;
  logic       busy_at_done;
  logic       busy_at1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp)
      else begin
        nfail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Reference CRCs by polynomial long division of M(x)*x^n.
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] v;
    v = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [15:0] crc16_ref(input logic [63:0] m);
    logic [79:0] v;
    v = {m, 16'b0};
    for (int i = 79; i >= 16; i--)
      if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h11021;
    return v[15:0];
  endfunction

  function automatic int r1_start();
    return 49 + c_r1_dly;
  endfunction

  function automatic int data_start();
    return r1_start() + 8 + 8 * NWR;
  endfunction

  function automatic int drsp_start();
    return data_start() + 88 + c_d_dly;
  endfunction

  // MISO value the card presents during cycle j. The engine frames a response
  // at its first zero bit, so the card sends each response byte with bit 7 low.
  function automatic logic card_miso(input int j);
    int         rs;
    int         dr;
    logic [7:0] r1v;
    logic [7:0] dv;
    rs  = r1_start();
    dr  = drsp_start();
    r1v = c_r1 & 8'h7F;
    dv  = c_drsp & 8'h7F;
    if (j < rs)                       return 1'b1;
    if (j < rs + 8)                   return r1v[7 - (j - rs)];
    if (c_r1 != 8'h00)                return 1'b1;
    if (j < dr)                       return 1'b1;
    if (j < dr + 8)                   return dv[7 - (j - dr)];
    if ((dv & 8'h1F) != 8'h05)        return 1'b1;
    if (j < dr + 8 + c_busy_n)        return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] field(input int from, input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r = {r[62:0], mo[from + k]};
    return r;
  endfunction

  function automatic logic all_high(input int from, input int to);
    logic a;
    a = 1'b1;
    for (int k = from; k <= to; k++) a = a & mo[k];
    return a;
  endfunction

  // Expects start already raised; records MOSI until done or the cycle budget.
  task automatic capture(input int abort_at);
    int j;
    for (int i = 0; i < 512; i++) mo[i] = 1'b1;
    done_cyc = -1;
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b0;
    j = 1;
    while (j < MAXC) begin
      mo[j] = bus.mosi;
      if (j == 1) busy_at1 = bus.busy;
      if (bus.done) begin
        done_cnt++;
        done_cyc     = j;
        err_at_done  = bus.err;
        busy_at_done = bus.busy;
        break;
      end
      if (j == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mosi", bus.mosi, 1);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_done", bus.done, 0);
        return;
      end
      bus.miso = card_miso(j);
      @(negedge clk);
      j++;
    end
    bus.miso = 1'b1;
    chk("done_seen", (done_cyc >= 0), 1);
  endtask

  task automatic card_nominal(input logic [7:0] r1, input logic [7:0] drsp);
    c_r1     = r1;
    c_r1_dly = 3;
    c_drsp   = drsp;
    c_d_dly  = 2;
    c_busy_n = 20;
  endtask

  task automatic launch(input logic [15:0] a, input logic [63:0] d);
    bus.start = 1'b1;
    bus.addr  = a;
    bus.data  = d;
  endtask

  int ds;
  int dcount;
  int bcount;

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.addr  = '0;
    bus.data  = '0;
    bus.miso  = 1'b1;
    card_nominal(8'h00, 8'hE5);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_mosi", bus.mosi, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err",  bus.err,  0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);

    // Nominal write: addr 0, data 0 -> R1 at cycle 52, data at 68, done at 187
    card_nominal(8'h00, 8'hE5);
    launch(16'h0000, 64'h0);
    capture(-1);
    ds = data_start();
    chk("nom_busy_first", busy_at1, 1);
    chk("nom_cmd_hi",   field(1, 40), 64'h58_0000_0000);
    chk("nom_cmd_crc7", field(41, 7), crc7_ref(40'h58_0000_0000));
    chk("nom_cmd_stop", mo[48], 1);
    chk("nom_gap_high", all_high(49, ds - 1), 1);
    chk("nom_token",    field(ds, 8), 8'hFE);
    chk("nom_payload",  field(ds + 8, 64), 64'h0);
    chk("nom_crc16",    field(ds + 72, 16), 16'h0000);
    chk("nom_done_cyc", done_cyc, 187);
    chk("nom_err",      err_at_done, 0);
    chk("nom_busy_done", busy_at_done, 0);
    @(negedge clk);
    chk("nom_done_1cyc", bus.done, 0);

    // Payload ordering: arg field and MSB-first data bits
    card_nominal(8'h00, 8'hE5);
    launch(16'h1234, 64'h0123_4567_89AB_CDEF);
    capture(-1);
    ds = data_start();
    chk("ord_arg",     field(9, 32), 32'h0000_1234);
    chk("ord_crc7",    field(41, 7), crc7_ref(40'h58_0000_1234));
    chk("ord_first",   field(ds + 8, 8), 8'h01);
    chk("ord_last",    field(ds + 64, 8), 8'hEF);
    chk("ord_payload", field(ds + 8, 64), 64'h0123_4567_89AB_CDEF);
    chk("ord_crc16",   field(ds + 72, 16), crc16_ref(64'h0123_4567_89AB_CDEF));
    chk("ord_err",     err_at_done, 0);
    @(negedge clk);

    // R1 error: R1 begins at cycle 52, done 8 cycles later, MOSI stays high
    card_nominal(8'h04, 8'hE5);
    launch(16'h0042, 64'hDEAD_BEEF_0000_0001);
    capture(-1);
    chk("r1_done_cyc", done_cyc, 60);
    chk("r1_err",      err_at_done, 1);
    chk("r1_no_token", all_high(49, 60), 1);
    @(negedge clk);

    // Data rejected: response status 101, no busy phase -> done at 158+8
    card_nominal(8'h00, 8'hEB);
    launch(16'h0007, 64'hFFFF_FFFF_FFFF_FFFF);
    capture(-1);
    chk("rej_done_cyc", done_cyc, 166);
    chk("rej_err",      err_at_done, 2);
    @(negedge clk);

    // Timeout: card silent, 50 wait cycles after CMD -> done at cycle 99
    card_nominal(8'h00, 8'hE5);
    c_r1_dly = 1000;
    launch(16'h0001, 64'h1);
    capture(-1);
    chk("tmo_done_cyc", done_cyc, 99);
    chk("tmo_err",      err_at_done, 3);

    // Back-to-back: start held through the DONE cycle, accepted in IDLE
    card_nominal(8'h00, 8'hE5);
    launch(16'h00FF, 64'hFFFF_0000_AAAA_5555);
    @(negedge clk);
    chk("b2b_idle_busy", bus.busy, 0);
    chk("b2b_idle_mosi", bus.mosi, 1);
    chk("b2b_err_hold",  bus.err,  3);
    capture(-1);
    chk("b2b_arg",      field(9, 32), 32'h0000_00FF);
    chk("b2b_payload",  field(data_start() + 8, 64), 64'hFFFF_0000_AAAA_5555);
    chk("b2b_done_cyc", done_cyc, 187);
    chk("b2b_err",      err_at_done, 0);
    @(negedge clk);

    // Reset in the middle of the data phase: no done pulse afterwards
    card_nominal(8'h00, 8'hE5);
    launch(16'h0ABC, 64'h5555_AAAA_5555_AAAA);
    capture(100);
    bus.miso = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    bcount = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (bus.done) dcount++;
      if (bus.busy) bcount++;
    end
    chk("post_rst_done", dcount, 0);
    chk("post_rst_busy", bcount, 0);
    chk("post_rst_mosi", bus.mosi, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/sd_write_engine.md
Name: sd_write_engine

Overview:
- Low-level SD-card write front-end that sits directly downstream of the DRAM-to-SD bridge controller.
- Takes one 64-bit word plus a 16-bit block address and serialises the full SD write transaction on a 1-bit MOSI/MISO pair:
  - CMD24 frame,
  - R1 response,
  - data token,
  - 64-bit payload,
  - CRC16,
  - data response,
  - busy release.
- Reports completion and an error code to the controller.

Parameters:
NWR, 1, gap between R1 end and data token, in units of 8 cycles (MOSI held high)
TIMEOUT, 10000, max cycles spent in any wait state before abort

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; accepted only in IDLE
addr  input  16  SD block address, zero-extended to 32-bit CMD24 argument
data  input  64  payload, sent MSB first
miso  input  1  serial data from card, sampled on rising edge
mosi  output  1  serial data to card, registered, idles high
busy  output  1  high from the cycle after start accepted until done
done  output  1  one-cycle pulse at end of transaction
err  output  2  valid while done=1: 0 ok, 1 R1 nonzero, 2 data rejected, 3 timeout

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: mosi=1, busy=0, done=0, err=0.
  - State=IDLE; all counters and latches are cleared.
  - Reset mid-transaction aborts immediately with no done pulse.
- IDLE:
  - On start=1, latch addr and data, go to CMD.
  - start is ignored in every other state.
- CMD, 48 cycles:
  - mosi carries {2'b01, 6'd24, 16'h0000, addr, CRC7, 1'b1}, bit 47 first.
  - Bit 47 is driven in the cycle after start.
  - CRC7 uses polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
- WAIT_RSP:
  - mosi=1; wait for the first sample with miso=0.
  - That sample is R1 bit7; go to RSP.
- RSP:
  - Shift in the remaining 7 bits.
  - R1 == 8'h00 -> GAP; otherwise -> DONE with err=1.
- GAP: mosi=1 for 8*NWR cycles.
- DATA, 88 cycles, MSB first: token 8'hFE, then 64 data bits, then CRC16.
  - CRC16 uses polynomial x^16+x^12+x^5+1 (CCITT), initial 0, computed over the 64 data bits only.
- WAIT_DRSP:
  - mosi=1; the first miso=0 sample is bit7 of the data response; go to DRSP.
- DRSP:
  - Shift in 7 more bits.
  - If (resp & 8'h1F) == 8'h05, go to BUSY; else DONE with err=2.
- BUSY: the card holds miso=0; on the first miso=1 sample, go to DONE with err=0.
- Timeout:
  - Each of WAIT_RSP, WAIT_DRSP and BUSY has a cycle counter that restarts on entry.
  - Reaching TIMEOUT cycles -> DONE with err=3.
- DONE:
  - done=1 and err valid for exactly one cycle; busy drops in the same cycle.
  - Next state is IDLE; a new start is accepted the cycle after done.
- Latency (no waits):
  - Cycle of the first mosi bit = 1 after start.
  - done comes at least 48 + 8 + 8*NWR + 88 + 8 + 1 cycles after start, plus the card's wait cycles.
- Simultaneous events:
  - start in the DONE cycle is ignored.
  - A miso=0 sample during CMD/GAP/DATA is ignored.
- err holds its last value between transactions; done is the only strobe.

Test Plan:
- Reset check:
  - Assert rst_n=0 mid-DATA.
  - Required: mosi=1, busy=0, done=0 immediately (asynchronous); no done pulse afterwards.
- Nominal write, NWR=1:
  - Stimulus: start with addr=16'h0000, data=64'h0, card model answers R1=8'h00 after 3 cycles, data response 8'hE5, busy 20 cycles.
  - Frame: mosi frame bits 47..8 = 40'h5800000000; CRC7 matches the bench model.
  - Payload: token 8'hFE, 64 zero bits, CRC16 16'h0000.
  - Result: done=1, err=0.
- Payload ordering:
  - Stimulus: data=64'h0123456789ABCDEF, addr=16'h1234.
  - Required: arg field = 32'h00001234; data bits appear MSB first (first byte 8'h01, last byte 8'hEF); CRC16 matches the model.
- R1 error: card returns R1=8'h04 -> no data token is sent; done pulse with err=1 exactly 8 cycles after R1 start.
- Data rejected: card returns data response 8'hEB (status 101) -> done with err=2, BUSY state skipped.
- Timeout and back-to-back:
  - Timeout: miso held high after CMD, TIMEOUT=50 -> done with err=3 50 cycles after CMD end.
  - Back-to-back: start asserted the cycle after done is accepted.
